// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, register indices and ALU/write-back selectors
// for the mips_harvard_cpu slice.
package mips_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   localparam logic [4:0] RT_BLTZ = 5'd0;
   localparam logic [4:0] RT_BGEZ = 5'd1;

   localparam logic [4:0] REG_V0 = 5'd2;
   localparam logic [4:0] REG_RA = 5'd31;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
   } alu_op_e;

   typedef enum logic [2:0] {
      WB_ALU, WB_MEM, WB_LINK, WB_HI, WB_LO
   } wb_sel_e;

endpackage

// File: rtl/mips_harvard_cpu_if.sv
// Instruction and data bus bundle between the CPU (master) and the
// external instruction/data memories (slave); both reads are combinational.
interface mips_harvard_cpu_if;
   logic [31:0] instr_address;
   logic [31:0] instr_readdata;
   logic [31:0] data_address;
   logic        data_write;
   logic        data_read;
   logic [31:0] data_writedata;
   logic [31:0] data_readdata;

   modport master (
      output instr_address, data_address, data_write, data_read, data_writedata,
      input  instr_readdata, data_readdata
   );

   modport slave (
      input  instr_address, data_address, data_write, data_read, data_writedata,
      output instr_readdata, data_readdata
   );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 general purpose register file: two combinational read ports, one
// write port, $0 reads as zero, asynchronous active-low clear, $2 exported.
module mips_regfile
   import mips_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_a_i,
   input  logic [4:0]  raddr_b_i,
   output logic [31:0] rdata_a_o,
   output logic [31:0] rdata_b_o,
   output logic [31:0] v0_o
);

   logic [31:0] regs_q [32];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (we_i && (waddr_i != 5'd0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
   assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];
   assign v0_o      = regs_q[REG_V0];

endmodule

// File: rtl/mips_harvard_cpu.sv
// Single-cycle MIPS I subset CPU with separate instruction/data buses and one
// branch delay slot. Define MIPS_MULT_DIV_EN to add HI/LO and multiply/divide.
module mips_harvard_cpu
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clk_enable,
   output logic               active,
   output logic [31:0]        register_v0,
   mips_harvard_cpu_if.master bus
);

   logic [31:0] pc_q, pc_d, br_tgt_q, br_tgt_d;
   logic        br_pend_q, br_pend_d, active_q, active_d;

   logic [31:0] instr;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt, shamt_eff;
   logic [15:0] imm16;
   logic [31:0] imm_sext, imm_zext, pc_plus4, pc_plus8, br_target, j_target;
   logic [31:0] rs_val, rt_val, alu_b, alu_y, wb_data, imm_val, take_tgt;
   logic signed [31:0] rs_s, rt_s, alu_b_s;
   alu_op_e     alu_op;
   wb_sel_e     wb_sel;
   logic [4:0]  wr_addr;
   logic        use_imm, shift_var, wr_en, mem_rd, mem_wr, take, commit, exec_ok;

   assign instr     = bus.instr_readdata;
   assign opcode    = instr[31:26];
   assign rs        = instr[25:21];
   assign rt        = instr[20:16];
   assign rd        = instr[15:11];
   assign shamt     = instr[10:6];
   assign funct     = instr[5:0];
   assign imm16     = instr[15:0];
   assign imm_sext  = {{16{imm16[15]}}, imm16};
   assign imm_zext  = {16'd0, imm16};
   assign pc_plus4  = pc_q + 32'd4;
   assign pc_plus8  = pc_q + 32'd8;
   assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
   assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};

   assign commit  = active_q & clk_enable;
   assign exec_ok = active_q & reset;

   mips_regfile u_regfile (
      .clk_i     (clk),
      .rst_ni    (reset),
      .we_i      (commit & wr_en),
      .waddr_i   (wr_addr),
      .wdata_i   (wb_data),
      .raddr_a_i (rs),
      .raddr_b_i (rt),
      .rdata_a_o (rs_val),
      .rdata_b_o (rt_val),
      .v0_o      (register_v0)
   );

   assign rs_s    = rs_val;
   assign rt_s    = rt_val;
   assign alu_b   = use_imm ? imm_val : rt_val;
   assign alu_b_s = alu_b;

   always_comb begin
      alu_op    = ALU_ADD;
      wb_sel    = WB_ALU;
      use_imm   = 1'b0;
      imm_val   = imm_sext;
      shift_var = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = rd;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      take      = 1'b0;
      take_tgt  = br_target;
      case (opcode)
         OP_SPECIAL: begin
            wr_en = 1'b1;
            case (funct)
               FN_ADDU: alu_op = ALU_ADD;
               FN_SUBU: alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_XOR:  alu_op = ALU_XOR;
               FN_NOR:  alu_op = ALU_NOR;
               FN_SLT:  alu_op = ALU_SLT;
               FN_SLTU: alu_op = ALU_SLTU;
               FN_SLL:  alu_op = ALU_SLL;
               FN_SRL:  alu_op = ALU_SRL;
               FN_SRA:  alu_op = ALU_SRA;
               FN_SLLV: begin alu_op = ALU_SLL; shift_var = 1'b1; end
               FN_SRLV: begin alu_op = ALU_SRL; shift_var = 1'b1; end
               FN_SRAV: begin alu_op = ALU_SRA; shift_var = 1'b1; end
               FN_JR:   begin wr_en = 1'b0; take = 1'b1; take_tgt = rs_val; end
               FN_JALR: begin wb_sel = WB_LINK; take = 1'b1; take_tgt = rs_val; end
`ifdef MIPS_MULT_DIV_EN
               FN_MFHI: wb_sel = WB_HI;
               FN_MFLO: wb_sel = WB_LO;
`endif
               default: wr_en = 1'b0;
            endcase
         end
         OP_REGIMM: begin
            case (rt)
               RT_BLTZ: take = rs_val[31];
               RT_BGEZ: take = ~rs_val[31];
               default: take = 1'b0;
            endcase
         end
         OP_J:    begin take = 1'b1; take_tgt = j_target; end
         OP_JAL:  begin
            take = 1'b1; take_tgt = j_target;
            wr_en = 1'b1; wr_addr = REG_RA; wb_sel = WB_LINK;
         end
         OP_BEQ:  take = (rs_val == rt_val);
         OP_BNE:  take = (rs_val != rt_val);
         OP_BLEZ: take = (rs_s <= 32'sd0);
         OP_BGTZ: take = (rs_s > 32'sd0);
         OP_ADDIU: begin wr_en = 1'b1; wr_addr = rt; use_imm = 1'b1; end
         OP_SLTI:  begin wr_en = 1'b1; wr_addr = rt; use_imm = 1'b1; alu_op = ALU_SLT; end
         OP_SLTIU: begin wr_en = 1'b1; wr_addr = rt; use_imm = 1'b1; alu_op = ALU_SLTU; end
         OP_ANDI: begin
            wr_en = 1'b1; wr_addr = rt; use_imm = 1'b1; imm_val = imm_zext; alu_op = ALU_AND;
         end
         OP_ORI: begin
            wr_en = 1'b1; wr_addr = rt; use_imm = 1'b1; imm_val = imm_zext; alu_op = ALU_OR;
         end
         OP_XORI: begin
            wr_en = 1'b1; wr_addr = rt; use_imm = 1'b1; imm_val = imm_zext; alu_op = ALU_XOR;
         end
         OP_LUI: begin wr_en = 1'b1; wr_addr = rt; alu_op = ALU_LUI; end
         OP_LW: begin
            wr_en = 1'b1; wr_addr = rt; use_imm = 1'b1; wb_sel = WB_MEM; mem_rd = 1'b1;
         end
         OP_SW:   begin use_imm = 1'b1; mem_wr = 1'b1; end
         default: ;
      endcase
   end

   assign shamt_eff = shift_var ? rs_val[4:0] : shamt;

   always_comb begin
      case (alu_op)
         ALU_ADD:  alu_y = rs_val + alu_b;
         ALU_SUB:  alu_y = rs_val - alu_b;
         ALU_AND:  alu_y = rs_val & alu_b;
         ALU_OR:   alu_y = rs_val | alu_b;
         ALU_XOR:  alu_y = rs_val ^ alu_b;
         ALU_NOR:  alu_y = ~(rs_val | alu_b);
         ALU_SLT:  alu_y = {31'd0, (rs_s < alu_b_s)};
         ALU_SLTU: alu_y = {31'd0, (rs_val < alu_b)};
         ALU_SLL:  alu_y = rt_val << shamt_eff;
         ALU_SRL:  alu_y = rt_val >> shamt_eff;
         ALU_SRA:  alu_y = rt_s >>> shamt_eff;
         ALU_LUI:  alu_y = {imm16, 16'd0};
         default:  alu_y = 32'd0;
      endcase
   end

`ifdef MIPS_MULT_DIV_EN
   logic [31:0]        hi_q, lo_q, hi_d, lo_d;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;

   assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (opcode == OP_SPECIAL) begin
         case (funct)
            FN_MULT:  {hi_d, lo_d} = prod_s;
            FN_MULTU: {hi_d, lo_d} = prod_u;
            FN_DIV:   if (rt_val != 32'd0) begin lo_d = rs_s / rt_s; hi_d = rs_s % rt_s; end
            FN_DIVU:  if (rt_val != 32'd0) begin lo_d = rs_val / rt_val; hi_d = rs_val % rt_val; end
            FN_MTHI:  hi_d = rs_val;
            FN_MTLO:  lo_d = rs_val;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (commit) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end
`endif

   always_comb begin
      case (wb_sel)
         WB_MEM:  wb_data = bus.data_readdata;
         WB_LINK: wb_data = pc_plus8;
`ifdef MIPS_MULT_DIV_EN
         WB_HI:   wb_data = hi_q;
         WB_LO:   wb_data = lo_q;
`endif
         default: wb_data = alu_y;
      endcase
   end

   // A taken branch only arms the redirect; the delay slot runs next cycle.
   always_comb begin
      br_pend_d = take;
      br_tgt_d  = take_tgt;
      pc_d      = br_pend_q ? br_tgt_q : pc_plus4;
      active_d  = ~(br_pend_q && (br_tgt_q == HALT_ADDRESS));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q      <= RESET_VECTOR;
         br_tgt_q  <= '0;
         br_pend_q <= 1'b0;
         active_q  <= 1'b1;
      end else if (commit) begin
         pc_q      <= pc_d;
         br_tgt_q  <= br_tgt_d;
         br_pend_q <= br_pend_d;
         active_q  <= active_d;
      end
   end

   assign active             = active_q;
   assign bus.instr_address  = pc_q;
   assign bus.data_address   = alu_y;
   assign bus.data_writedata = rt_val;
   assign bus.data_read      = exec_ok & mem_rd;
   assign bus.data_write     = exec_ok & mem_wr;

endmodule

// File: tb/tb_mips_harvard_cpu.sv
// Scoreboard bench for mips_harvard_cpu: directed programs, expected stores,
// loads and halt state queued up front and popped by an independent monitor.
module tb_mips_harvard_cpu;

   localparam logic [31:0] BASE = 32'hBFC00000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clk_enable = 1'b1;
   logic        active;
   logic [31:0] register_v0;

   mips_harvard_cpu_if bus_if ();

   mips_harvard_cpu dut (
      .clk         (clk),
      .reset       (reset),
      .clk_enable  (clk_enable),
      .active      (active),
      .register_v0 (register_v0),
      .bus         (bus_if)
   );

   always #5 clk = ~clk;

   logic [31:0] imem [64];
   logic [31:0] dmem [64];
   logic [31:0] ioff;

   always_comb begin
      ioff = bus_if.instr_address - BASE;
      bus_if.instr_readdata = 32'd0;
      if (ioff < 32'd256) bus_if.instr_readdata = imem[ioff[7:2]];
   end

   assign bus_if.data_readdata = dmem[bus_if.data_address[7:2]];
   always @(posedge clk) if (bus_if.data_write) dmem[bus_if.data_address[7:2]] <= bus_if.data_writedata;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] prog    [$];
   logic [63:0] store_q [$];
   logic [31:0] load_q  [$];
   logic [31:0] halt_q  [$];
   logic        mon_prev_act;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Monitor: strobes are checked on committing cycles, halt on active falling.
   initial begin
      mon_prev_act = 1'b1;
      forever begin
         @(negedge clk);
         if (reset && clk_enable && bus_if.data_write) begin
            if (store_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL store_unexpected: got addr %h data %h expected no store",
                        bus_if.data_address, bus_if.data_writedata);
            end else begin
               logic [63:0] e;
               e = store_q.pop_front();
               check("store_addr", bus_if.data_address, e[63:32]);
               check("store_data", bus_if.data_writedata, e[31:0]);
            end
         end
         if (reset && clk_enable && bus_if.data_read) begin
            if (load_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL load_unexpected: got addr %h expected no load", bus_if.data_address);
            end else begin
               check("load_addr", bus_if.data_address, load_q.pop_front());
            end
         end
         if (reset && mon_prev_act && !active) begin
            if (halt_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL halt_unexpected: got v0 %h expected no halt", register_v0);
            end else begin
               check("halt_v0", register_v0, halt_q.pop_front());
               check("halt_pc", bus_if.instr_address, 32'h0);
            end
         end
         mon_prev_act = reset ? active : 1'b1;
      end
   end

   task automatic run_prog(input string tag, input int stall_at, input logic [31:0] stall_pc,
                           input logic [31:0] stall_v0, input logic [31:0] exp_v0);
      int cyc;
      for (int i = 0; i < 64; i++) imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
      halt_q.push_back(exp_v0);
      clk_enable = 1'b1;
      @(negedge clk); #2 reset = 1'b0;
      #1;
      check({tag, "_rst_pc"}, bus_if.instr_address, BASE);
      check({tag, "_rst_active"}, 32'(active), 32'd1);
      check({tag, "_rst_v0"}, register_v0, 32'd0);
      check({tag, "_rst_strobes"}, {30'd0, bus_if.data_write, bus_if.data_read}, 32'd0);
      @(posedge clk); #2 reset = 1'b1;
      if (stall_at > 0) begin
         repeat (stall_at) @(posedge clk);
         #2 clk_enable = 1'b0;
         repeat (3) begin
            @(posedge clk); #2;
            check({tag, "_stall_pc"}, bus_if.instr_address, stall_pc);
            check({tag, "_stall_v0"}, register_v0, stall_v0);
         end
         clk_enable = 1'b1;
      end
      cyc = 0;
      while (active && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_halt_timeout"}, 32'(active), 32'd0);
      repeat (4) @(negedge clk);
      check({tag, "_post_pc"}, bus_if.instr_address, 32'h0);
      check({tag, "_post_v0"}, register_v0, exp_v0);
      check({tag, "_post_active"}, 32'(active), 32'd0);
      check({tag, "_stores_left"}, 32'(store_q.size()), 32'd0);
      check({tag, "_loads_left"}, 32'(load_q.size()), 32'd0);
      check({tag, "_halts_left"}, 32'(halt_q.size()), 32'd0);
      store_q.delete(); load_q.delete(); halt_q.delete();
   endtask

   task automatic push_slt_body(input logic [5:0] fn);
      prog.push_back(enc_i(6'h09, 5'd4, 5'd4, 16'hFFFF));       // ADDIU $4,$4,-1
      prog.push_back(enc_r(5'd0, 5'd4, 5'd4, 5'd16, 6'h00));    // SLL $4,$4,16
      prog.push_back(enc_i(6'h09, 5'd4, 5'd4, 16'hFFB3));       // ADDIU $4,$4,0xFFB3
      prog.push_back(enc_i(6'h09, 5'd5, 5'd5, 16'd11));         // ADDIU $5,$5,11
      prog.push_back(enc_i(6'h2B, 5'd0, 5'd4, 16'd0));          // SW $4,0($0)
      prog.push_back(enc_r(5'd4, 5'd5, 5'd2, 5'd0, fn));        // SLT/SLTU $2,$4,$5
      prog.push_back(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));     // JR $0
      prog.push_back(enc_i(6'h09, 5'd0, 5'd0, 16'd0));          // ADDIU $0,$0,0
      store_q.push_back({32'h0, 32'hFFFEFFB3});
   endtask

   task automatic push_branch_prog();
      prog.delete();
      prog.push_back(enc_i(6'h09, 5'd0, 5'd2, 16'd1));          // ADDIU $2,$0,1
      prog.push_back(enc_i(6'h05, 5'd2, 5'd0, 16'd2));          // BNE $2,$0,+2
      prog.push_back(enc_i(6'h09, 5'd2, 5'd2, 16'd2));          // delay: ADDIU $2,$2,2
      prog.push_back(enc_i(6'h09, 5'd2, 5'd2, 16'd100));        // skipped
      prog.push_back({6'h03, 26'h3F00007});                     // JAL BFC0001C
      prog.push_back(enc_i(6'h09, 5'd2, 5'd2, 16'd4));          // delay: ADDIU $2,$2,4
      prog.push_back(enc_i(6'h09, 5'd2, 5'd2, 16'd1000));       // skipped
      prog.push_back(enc_r(5'd2, 5'd31, 5'd2, 5'd0, 6'h21));    // ADDU $2,$2,$31
      prog.push_back(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));     // JR $0
      prog.push_back(32'd0);
   endtask

   initial begin
      prog.delete();
      push_slt_body(6'h2A);
      run_prog("slt", 0, 32'd0, 32'd0, 32'd1);

      prog.delete();
      prog.push_back(enc_i(6'h09, 5'd0, 5'd2, 16'd7));          // ADDIU $2,$0,7
      push_slt_body(6'h2B);
      run_prog("sltu", 0, 32'd0, 32'd0, 32'd0);

      prog.delete();
      prog.push_back(enc_i(6'h09, 5'd0, 5'd2, 16'd3));
      prog.push_back(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));     // JR $0
      prog.push_back(enc_i(6'h09, 5'd0, 5'd2, 16'd5));          // delay slot
      prog.push_back(enc_i(6'h09, 5'd0, 5'd2, 16'd9));          // never runs
      run_prog("dslot", 0, 32'd0, 32'd0, 32'd5);

      prog.delete();
      prog.push_back(enc_i(6'h09, 5'd0, 5'd5, 16'h1234));       // ADDIU $5,$0,0x1234
      prog.push_back(enc_i(6'h2B, 5'd0, 5'd5, 16'd8));          // SW $5,8($0)
      prog.push_back(enc_i(6'h23, 5'd0, 5'd2, 16'd8));          // LW $2,8($0)
      prog.push_back(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
      prog.push_back(32'd0);
      store_q.push_back({32'd8, 32'h00001234});
      load_q.push_back(32'd8);
      run_prog("mem", 0, 32'd0, 32'd0, 32'h00001234);

      push_branch_prog();
      run_prog("branch", 0, 32'd0, 32'd0, 32'hBFC0001F);

      push_branch_prog();
      run_prog("stall", 2, BASE + 32'd8, 32'd1, 32'hBFC0001F);

      prog.delete();
      prog.push_back(enc_i(6'h0F, 5'd0, 5'd3, 16'h8000));       // LUI $3,0x8000
      prog.push_back(enc_r(5'd0, 5'd3, 5'd3, 5'd4, 6'h03));     // SRA $3,$3,4
      prog.push_back(enc_i(6'h0B, 5'd0, 5'd2, 16'hFFFF));       // SLTIU $2,$0,-1
      prog.push_back(enc_i(6'h01, 5'd3, 5'd0, 16'd2));          // BLTZ $3,+2
      prog.push_back(enc_i(6'h0D, 5'd2, 5'd2, 16'h8000));       // delay: ORI $2,$2,0x8000
      prog.push_back(enc_i(6'h09, 5'd0, 5'd2, 16'd0));          // skipped
      prog.push_back(enc_i(6'h2B, 5'd0, 5'd3, 16'd4));          // SW $3,4($0)
      prog.push_back(enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
      prog.push_back(32'd0);
      store_q.push_back({32'd4, 32'hF8000000});
      run_prog("misc", 0, 32'd0, 32'd0, 32'h00008001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

endmodule
